// File: rtl/tdm_demux4.sv
// Receive side of a 4:1 slot-multiplexed lane: tracks slot position from sync,
// stages slots 0..2 and publishes all four channels as one coherent frame.
//
// state (locked, slot) | meaning
// ---------------------+-----------------------------------------------
// 0, x                 | hunting: waiting for first sync, samples dropped
// 1, 0                 | aligned, next strobe is slot 0
// 1, 1..2              | mid-frame, staging into s1/s2
// 1, 3                 | next strobe completes the frame and publishes it
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sync,
    input  logic [W-1:0] din,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err,
    output logic [7:0]   err_cnt
);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    logic [1:0]   slot;
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot        <= SLOT0;
            locked      <= 1'b0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            o0          <= '0;
            o1          <= '0;
            o2          <= '0;
            o3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                if (!locked) begin
                    if (sync) begin
                        locked <= 1'b1;
                        s0     <= din;
                        slot   <= SLOT1;
                    end
                end else if (sync) begin
                    // A sync anywhere but slot 0 abandons the partial frame and
                    // realigns on this strobe; s1/s2 get rewritten before next publish.
                    if (slot != SLOT0) begin
                        sync_err <= 1'b1;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                    end
                    s0   <= din;
                    slot <= SLOT1;
                end else begin
                    case (slot)
                        SLOT0: begin
                            s0   <= din;
                            slot <= SLOT1;
                        end
                        SLOT1: begin
                            s1   <= din;
                            slot <= SLOT2;
                        end
                        SLOT2: begin
                            s2   <= din;
                            slot <= SLOT3;
                        end
                        default: begin
                            o0          <= s0;
                            o1          <= s1;
                            o2          <= s2;
                            o3          <= din;
                            frame_valid <= 1'b1;
                            slot        <= SLOT0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=1): framing, gaps, back-to-back frames,
// misplaced sync handling, error-count saturation and mid-frame reset.
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync;
    logic [0:0] din;
    logic [0:0] o0, o1, o2, o3;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_cnt;
    logic [3:0] o_all;

    int errors = 0;
    int checks = 0;

    assign o_all = {o0, o1, o2, o3};

    tdm_demux4 #(.W(1)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .frame_valid(frame_valid), .locked(locked),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobe; en stays high afterwards so consecutive calls are back-to-back.
    task automatic strobe(input logic s, input logic d);
        @(negedge clk);
        en   = 1'b1;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en   = 1'b0;
            sync = 1'b1;
            din  = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_all, frame_valid, locked, sync_err, err_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: o=%b fv=%b lk=%b se=%b cnt=%0d, want all 0",
                     o_all, frame_valid, locked, sync_err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_sync;
        int fv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0, 1'b1);
            if (frame_valid) fv_seen++;
        end
        idle(1);
        checks++;
        if (locked !== 1'b0 || fv_seen != 0 || o_all !== 4'b0000) begin
            errors++;
            $display("FAIL no_sync: lk=%b fv_count=%0d o=%b, want lk=0 fv_count=0 o=0000",
                     locked, fv_seen, o_all);
        end
    endtask

    task automatic test_frame;
        strobe(1'b1, 1'b1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise: lk=%b, want 1", locked);
        end
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1);
        checks++;
        if (frame_valid !== 1'b0 || o_all !== 4'b0000) begin
            errors++;
            $display("FAIL frame_partial: fv=%b o=%b, want fv=0 o=0000", frame_valid, o_all);
        end
        strobe(1'b0, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || o_all !== 4'b1011 || locked !== 1'b1) begin
            errors++;
            $display("FAIL frame_out: fv=%b o=%b lk=%b, want fv=1 o=1011 lk=1",
                     frame_valid, o_all, locked);
        end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0 || o_all !== 4'b1011) begin
            errors++;
            $display("FAIL frame_pulse_width: fv=%b o=%b, want fv=0 o=1011", frame_valid, o_all);
        end
    endtask

    task automatic test_gaps;
        logic [3:0] bits = 4'b1011;
        int fv_early = 0;
        for (int i = 0; i < 4; i++) begin
            strobe(i == 0, bits[3-i]);
            if (i < 3 && frame_valid) fv_early++;
            if (i == 3) begin
                checks++;
                if (frame_valid !== 1'b1 || o_all !== 4'b1011) begin
                    errors++;
                    $display("FAIL gap_frame: fv=%b o=%b, want fv=1 o=1011", frame_valid, o_all);
                end
            end
            idle(3);
            if (frame_valid) fv_early++;
        end
        checks++;
        if (fv_early != 0) begin
            errors++;
            $display("FAIL gap_fv_count: extra pulses=%0d, want 0", fv_early);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits = 8'b1011_0100;
        int se_seen = 0;
        for (int i = 0; i < 8; i++) begin
            strobe((i % 4) == 0, bits[7-i]);
            if (sync_err) se_seen++;
            if (i == 3) begin
                checks++;
                if (frame_valid !== 1'b1 || o_all !== 4'b1011) begin
                    errors++;
                    $display("FAIL b2b_first: fv=%b o=%b, want fv=1 o=1011", frame_valid, o_all);
                end
            end else if (i == 7) begin
                checks++;
                if (frame_valid !== 1'b1 || o_all !== 4'b0100) begin
                    errors++;
                    $display("FAIL b2b_second: fv=%b o=%b, want fv=1 o=0100", frame_valid, o_all);
                end
            end else if (i > 3) begin
                checks++;
                if (frame_valid !== 1'b0 || o_all !== 4'b1011) begin
                    errors++;
                    $display("FAIL b2b_mid%0d: fv=%b o=%b, want fv=0 o=1011", i, frame_valid, o_all);
                end
            end
        end
        idle(1);
        checks++;
        if (se_seen != 0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_no_err: sync_err pulses=%0d cnt=%0d, want 0 and 0", se_seen, err_cnt);
        end
    endtask

    task automatic test_misplaced;
        strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || err_cnt !== 8'd1 || frame_valid !== 1'b0 ||
            o_all !== 4'b0100 || locked !== 1'b1) begin
            errors++;
            $display("FAIL misplaced: se=%b cnt=%0d fv=%b o=%b lk=%b, want se=1 cnt=1 fv=0 o=0100 lk=1",
                     sync_err, err_cnt, frame_valid, o_all, locked);
        end
        strobe(1'b0, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL misplaced_pulse: se=%b fv=%b, want se=0 fv=0", sync_err, frame_valid);
        end
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || o_all !== 4'b0010 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL resync_frame: fv=%b o=%b cnt=%0d, want fv=1 o=0010 cnt=1",
                     frame_valid, o_all, err_cnt);
        end
        idle(1);
    endtask

    task automatic test_saturate;
        logic [7:0] exp_cnt = 8'd1;
        strobe(1'b1, 1'b0);
        for (int i = 1; i <= 260; i++) begin
            strobe(1'b1, 1'b0);
            exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
            if (i == 253 || i == 254 || i == 260) begin
                checks++;
                if (err_cnt !== exp_cnt || sync_err !== 1'b1 || frame_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL saturate_%0d: cnt=%0d se=%b fv=%b, want cnt=%0d se=1 fv=0",
                             i, err_cnt, sync_err, frame_valid, exp_cnt);
                end
            end
        end
        checks++;
        if (o_all !== 4'b0010) begin
            errors++;
            $display("FAIL saturate_outputs: o=%b, want 0010", o_all);
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_all, frame_valid, locked, sync_err, err_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid: o=%b fv=%b lk=%b se=%b cnt=%0d, want all 0",
                     o_all, frame_valid, locked, sync_err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || frame_valid !== 1'b0 || o_all !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_unlocked: lk=%b fv=%b o=%b, want lk=0 fv=0 o=0000",
                     locked, frame_valid, o_all);
        end
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || o_all !== 4'b0111 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_frame: fv=%b o=%b cnt=%0d, want fv=1 o=0111 cnt=0",
                     frame_valid, o_all, err_cnt);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_no_sync();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_misplaced();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
